// File: rtl/nand_gate.sv
// nand_gate: WIDTH-lane 3-input NAND with a registered copy
// and a lane-0 truth-table coverage tracker.
module nand_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             in_valid,
  input  logic             cov_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [7:0]       cov,
  output logic             cov_all
);

  logic [2:0] idx;

  assign y       = ~(a & b & c);
  assign idx     = {a[0], b[0], c[0]};
  assign cov_all = &cov;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= y;
      end
    end
  end

  // Clear wins over a same-cycle sample, which is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cov <= 8'h00;
    end else if (cov_clr) begin
      cov <= 8'h00;
    end else if (in_valid) begin
      cov[idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nand_gate.sv
// tb_nand_gate: directed steps with a y_q scoreboard queue,
// checked by immediate assertions.
module tb_nand_gate;

  logic       clk = 1'b0;
  logic       rst, iv, clr;
  logic [0:0] a, b, c;
  logic [0:0] y, y_q;
  logic       out_valid, cov_all;
  logic [7:0] cov;

  logic [3:0] a4, b4, c4;
  logic       iv4;
  logic [3:0] y4, y_q4;
  logic       ov4, cov_all4;
  logic [7:0] cov4;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  logic [7:0] cov_m;
  logic       ov_m;
  logic [7:0] last_yq;
  logic [2:0] cur_abc;

  always #5 clk = ~clk;

  nand_gate #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .in_valid(iv), .cov_clr(clr), .y(y), .y_q(y_q),
    .out_valid(out_valid), .cov(cov), .cov_all(cov_all)
  );

  nand_gate #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4),
    .in_valid(iv4), .cov_clr(clr), .y(y4), .y_q(y_q4),
    .out_valid(ov4), .cov(cov4), .cov_all(cov_all4)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] abc,
                        input logic v,
                        input logic cl,
                        input logic r);
    {a, b, c} = abc;
    iv = v; clr = cl; rst = r;
    cur_abc = abc;
    #1;
    chk("y_comb", {7'b0, y}, {7'b0, ~&abc});
    if (v && !r) sb.push_back({7'b0, ~&abc});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      cov_m = 8'h00; ov_m = 1'b0; last_yq = 8'h00;
    end else begin
      ov_m = iv;
      if (clr) cov_m = 8'h00;
      else if (iv) cov_m[cur_abc] = 1'b1;
    end
    #1;
    chk("out_valid", {7'b0, out_valid}, {7'b0, ov_m});
    if (ov_m) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $error("FAIL sb_empty observed=0 expected=1");
      end else begin
        last_yq = sb.pop_front();
      end
    end
    chk("y_q", {7'b0, y_q}, last_yq);
    chk("cov", cov, cov_m);
    chk("cov_all", {7'b0, cov_all}, {7'b0, &cov_m});
  endtask

  initial begin
    a4 = '0; b4 = '0; c4 = '0; iv4 = 1'b0;
    cov_m = 8'h00; ov_m = 1'b0; last_yq = 8'h00;

    // reset
    set_in(3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_yq4", {4'b0, y_q4}, 8'h00);
    chk("rst_ov4", {7'b0, ov4}, 8'h00);
    chk("rst_cov4", cov4, 8'h00);

    // exhaustive sweep
    for (int k = 0; k < 8; k++) begin
      set_in(k[2:0], 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("sweep_cov", cov, 8'hFF);
    chk("sweep_all", {7'b0, cov_all}, 8'h01);

    // reset mid-sweep, y keeps tracking inputs
    set_in(3'b000, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(3'b001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_yq", {7'b0, y_q}, 8'h01);
    set_in(3'b111, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rst_yq", {7'b0, y_q}, 8'h00);
    chk("rst_cov", cov, 8'h00);
    set_in(3'b110, 1'b1, 1'b0, 1'b1);
    tick();

    // valid gating
    set_in(3'b111, 1'b0, 1'b0, 1'b0);
    tick();
    chk("gate_cov", cov, 8'h00);
    set_in(3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("gate_yq", {7'b0, y_q}, 8'h01);
    chk("gate_cov1", cov, 8'h01);
    set_in(3'b111, 1'b0, 1'b0, 1'b0);
    tick();
    chk("hold_yq", {7'b0, y_q}, 8'h01);

    // clear priority
    for (int k = 1; k < 4; k++) begin
      set_in(k[2:0], 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("cov_0f", cov, 8'h0F);
    set_in(3'b111, 1'b1, 1'b1, 1'b0);
    tick();
    chk("clr_cov", cov, 8'h00);
    chk("clr_yq", {7'b0, y_q}, 8'h00);
    chk("clr_ov", {7'b0, out_valid}, 8'h01);

    // partial coverage
    set_in(3'b000, 1'b1, 1'b0, 1'b0); tick();
    set_in(3'b011, 1'b1, 1'b0, 1'b0); tick();
    set_in(3'b011, 1'b1, 1'b0, 1'b0); tick();
    set_in(3'b101, 1'b1, 1'b0, 1'b0); tick();
    chk("part_cov", cov, 8'b0010_1001);
    chk("part_all", {7'b0, cov_all}, 8'h00);

    // multi-lane: lane 0 index is {1,0,0} = 4
    a4 = 4'b1111; b4 = 4'b1010; c4 = 4'b1100; iv4 = 1'b1;
    set_in(3'b000, 1'b0, 1'b0, 1'b0);
    chk("y4_comb", {4'b0, y4}, 8'h07);
    tick();
    iv4 = 1'b0;
    chk("y4_q", {4'b0, y_q4}, 8'h07);
    chk("ov4", {7'b0, ov4}, 8'h01);
    chk("cov4", cov4, 8'h10);
    chk("cov4_all", {7'b0, cov_all4}, 8'h00);
    tick();
    chk("ov4_drop", {7'b0, ov4}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
